result_uart_tx: RTL

- Downstream stage of the eye-test core.
- Watches the core's start_to_send level. On its rising edge, latches the final results (sight size, astigmatism flag, colour-test flag).
- Serialises the results as a fixed 4-byte 8N1 UART packet on the RS232 TX pin, then reports completion.
- Owns the whole RS232 path: sequencing, bit timing, checksum.

---
 rtl/result_uart_tx_if.sv | 31 +++
 rtl/result_uart_tx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/result_uart_tx_if.sv
// Result/UART bundle between the eye-test core and result_uart_tx.
// master = core side (drives results), slave = transmitter side.
interface result_uart_tx_if;
    logic       i_start;
    logic [3:0] i_size;
    logic       i_astigmatism;
    logic       i_color;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    modport master (
        output i_start,
        output i_size,
        output i_astigmatism,
        output i_color,
        input  o_tx,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_size,
        input  i_astigmatism,
        input  i_color,
        output o_tx,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/result_uart_tx.sv
// Latches eye-test results on a rising start edge and sends a 4-byte UART
// packet (header, size, flags, xor checksum). RESULT_UART_TX_PARITY_EN adds even parity.
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic           i_clk,
    input  logic           i_rst,
    result_uart_tx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
`ifdef RESULT_UART_TX_PARITY_EN
        , PARITY
`endif
    } state_e;

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic        start_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  b1_q, b1_d;
    logic [7:0]  b2_q, b2_d;
    logic        tx_q, tx_d;

    logic        trig;
    logic        bit_end;
    logic [7:0]  b3;
    logic [7:0]  next_byte;

    assign trig    = bus.i_start & ~start_q;
    assign bit_end = (cnt_q == LAST);
    assign b3      = HEADER_BYTE ^ b1_q ^ b2_q;

    assign next_byte = (byte_q == 2'd0) ? b1_q :
                       (byte_q == 2'd1) ? b2_q : b3;

`ifdef RESULT_UART_TX_PARITY_EN
    logic [7:0] cur_byte;
    assign cur_byte = (byte_q == 2'd0) ? HEADER_BYTE :
                      (byte_q == 2'd1) ? b1_q :
                      (byte_q == 2'd2) ? b2_q : b3;
`endif

    // Sequencer: bit timing, byte/bit indexing and the registered tx level
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        tx_d    = 1'b1;

        case (state_q)
            IDLE, DONE: begin
                if (trig) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    shift_d = HEADER_BYTE;
                    b1_d    = {4'h0, bus.i_size};
                    b2_d    = {6'b0, bus.i_color, bus.i_astigmatism};
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef RESULT_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        shift_d = next_byte;
                        state_d = START;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef RESULT_UART_TX_PARITY_EN
            PARITY:  tx_d = ^cur_byte;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            start_q <= bus.i_start;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.o_tx   = tx_q;
    assign bus.o_busy = (state_q != IDLE) && (state_q != DONE);
    assign bus.o_done = (state_q == DONE);

endmodule
